// File: rtl/decade_counter_ctrl_if.sv
// Command handshake bundle for decade_counter_ctrl.
// Ports: cmd_valid/cmd_ready handshake, cmd_preset (4b), cmd_count (CNT_W).
interface decade_counter_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_preset;
    logic [CNT_W-1:0] cmd_count;

    modport master (
        output cmd_valid,
        output cmd_preset,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_preset,
        input  cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/decade_counter_ctrl.sv
// Loads, counts and checks an external synchronous decade counter.
// Ports: CLK, MR_n, cmd (slave), abort, P/Load/Enable/Q, result fields.
module decade_counter_ctrl #(
    parameter int CNT_W  = 8,
    parameter int WRAP_W = 4
) (
    input  logic                 CLK,
    input  logic                 MR_n,
    decade_counter_ctrl_if.slave cmd,
    input  logic                 abort,
    output logic [3:0]           P,
    output logic                 Load,
    output logic                 Enable,
    input  logic [3:0]           Q,
    output logic                 done,
    output logic                 mismatch,
    output logic                 err_preset,
    output logic                 aborted,
    output logic [WRAP_W-1:0]    wraps,
    output logic [3:0]           final_q
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COUNT,
        FINAL,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       exp_q;
    logic             accept;
    logic             bad;

    assign accept        = cmd.cmd_valid && (state == IDLE);
    assign bad           = cmd.cmd_preset > 4'd9;
    assign cmd.cmd_ready = (state == IDLE);
    assign Load          = (state == LOAD);
    assign Enable        = (state == COUNT);
    assign done          = (state == DONE);

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = bad ? DONE : LOAD;
                end
            end
            LOAD: begin
                state_n = (cnt_r != '0) ? COUNT : FINAL;
            end
            COUNT: begin
                // cnt_r still holds this cycle's tick, so 1 means last
                if (abort || cnt_r == CNT_W'(1)) begin
                    state_n = FINAL;
                end
            end
            FINAL: begin
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            P          <= '0;
            cnt_r      <= '0;
            exp_q      <= '0;
            mismatch   <= 1'b0;
            err_preset <= 1'b0;
            aborted    <= 1'b0;
            wraps      <= '0;
            final_q    <= '0;
        end else begin
            if (accept) begin
                mismatch   <= 1'b0;
                aborted    <= 1'b0;
                wraps      <= '0;
                final_q    <= '0;
                err_preset <= bad;
                cnt_r      <= cmd.cmd_count;
                P          <= bad ? 4'd0 : cmd.cmd_preset;
            end
            if (state == LOAD) begin
                exp_q <= P;
            end
            if (state == COUNT) begin
                if (Q != exp_q) begin
                    mismatch <= 1'b1;
                end
                if (exp_q == 4'd9) begin
                    exp_q <= 4'd0;
                    if (wraps != '1) begin
                        wraps <= wraps + WRAP_W'(1);
                    end
                end else begin
                    exp_q <= exp_q + 4'd1;
                end
                cnt_r <= cnt_r - CNT_W'(1);
                if (abort) begin
                    aborted <= 1'b1;
                end
            end
            if (state == FINAL) begin
                if (Q != exp_q) begin
                    mismatch <= 1'b1;
                end
                final_q <= Q;
            end
        end
    end

endmodule

// File: tb/tb_decade_counter_ctrl.sv
// Scoreboard bench for decade_counter_ctrl against a behavioural counter.
// Drives commands, models results, compares on each done pulse.
module tb_decade_counter_ctrl;

    logic       CLK;
    logic       MR_n;
    logic       abort;
    logic [3:0] P;
    logic       Load;
    logic       Enable;
    logic [3:0] Q;
    logic       done;
    logic       mismatch;
    logic       err_preset;
    logic       aborted;
    logic [3:0] wraps;
    logic [3:0] final_q;
    logic       stuck;
    logic [3:0] cq = 4'd0;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int         lat;
        logic       mm;
        logic       err;
        logic       ab;
        logic [3:0] wr;
        logic [3:0] fq;
        int         loads;
        int         ens;
    } exp_t;

    exp_t sb[$];

    decade_counter_ctrl_if #(.CNT_W(8)) cif ();

    decade_counter_ctrl #(.CNT_W(8), .WRAP_W(4)) dut (
        .CLK        (CLK),
        .MR_n       (MR_n),
        .cmd        (cif),
        .abort      (abort),
        .P          (P),
        .Load       (Load),
        .Enable     (Enable),
        .Q          (Q),
        .done       (done),
        .mismatch   (mismatch),
        .err_preset (err_preset),
        .aborted    (aborted),
        .wraps      (wraps),
        .final_q    (final_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (Load) begin
            cq <= P;
        end else if (Enable) begin
            cq <= (cq == 4'd9) ? 4'd0 : cq + 4'd1;
        end
    end

    assign Q = stuck ? 4'd4 : cq;

    task automatic check(input string tag, input int got, input int want);
        n_chk++;
        if (got == want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic run(input int pre, input int cnt,
                       input int ab_at, input logic stk);
        exp_t e;
        exp_t g;
        int   ticks;
        int   n;
        int   loads;
        int   ens;
        int   v;
        logic hit;

        e.lat   = 1;
        e.mm    = 1'b0;
        e.err   = 1'b0;
        e.ab    = 1'b0;
        e.wr    = 4'd0;
        e.fq    = 4'd0;
        e.loads = 0;
        e.ens   = 0;
        if (pre > 9) begin
            e.err = 1'b1;
        end else begin
            ticks = (ab_at > 0 && ab_at <= cnt) ? ab_at : cnt;
            e.ab    = (ab_at > 0 && ab_at <= cnt);
            e.lat   = ticks + 3;
            e.loads = 1;
            e.ens   = ticks;
            for (int t = 0; t <= ticks; t++) begin
                v = (pre + t) % 10;
                if (t < ticks && v == 9 && e.wr != 4'd15) begin
                    e.wr = e.wr + 4'd1;
                end
                if (stk && v != 4) begin
                    e.mm = 1'b1;
                end
            end
            e.fq = stk ? 4'd4 : 4'((pre + ticks) % 10);
        end
        sb.push_back(e);

        @(negedge CLK);
        stuck          = stk;
        cif.cmd_valid  = 1'b1;
        cif.cmd_preset = 4'(pre);
        cif.cmd_count  = 8'(cnt);
        @(posedge CLK);
        n     = 0;
        loads = 0;
        ens   = 0;
        hit   = 1'b0;
        while (!hit && n < 400) begin
            @(negedge CLK);
            n++;
            cif.cmd_valid = 1'b0;
            if (Load) begin
                loads++;
                check("load_p", P, pre);
                check("ready_busy", cif.cmd_ready, 0);
            end
            if (Enable) begin
                ens++;
            end
            abort = Enable && (ens == ab_at);
            if (done) begin
                hit = 1'b1;
            end
        end
        abort = 1'b0;
        g = sb.pop_front();
        if (!hit) begin
            check("done_timeout", n, g.lat);
        end else begin
            check("latency", n, g.lat);
            check("mismatch", mismatch, g.mm);
            check("err_preset", err_preset, g.err);
            check("aborted", aborted, g.ab);
            check("wraps", wraps, g.wr);
            check("final_q", final_q, g.fq);
            check("loads", loads, g.loads);
            check("enables", ens, g.ens);
            @(negedge CLK);
            check("ready_after", cif.cmd_ready, 1);
            check("done_pulse", done, 0);
        end
    endtask

    initial begin
        int seen;
        MR_n           = 1'b0;
        abort          = 1'b0;
        stuck          = 1'b0;
        cif.cmd_valid  = 1'b0;
        cif.cmd_preset = 4'd0;
        cif.cmd_count  = 8'd0;
        repeat (3) @(negedge CLK);
        check("rst_ready", cif.cmd_ready, 1);
        check("rst_load", Load, 0);
        check("rst_enable", Enable, 0);
        check("rst_done", done, 0);
        check("rst_p", P, 0);
        check("rst_wraps", wraps, 0);
        check("rst_final_q", final_q, 0);
        check("rst_flags", {mismatch, err_preset, aborted}, 0);
        MR_n = 1'b1;

        run(7, 5, 0, 1'b0);
        run(3, 0, 0, 1'b0);
        run(0, 25, 0, 1'b0);
        run(12, 0, 0, 1'b0);
        run(4, 3, 0, 1'b1);
        run(8, 10, 2, 1'b0);
        run(0, 200, 0, 1'b0);

        @(negedge CLK);
        cif.cmd_valid  = 1'b1;
        cif.cmd_preset = 4'd2;
        cif.cmd_count  = 8'd10;
        @(negedge CLK);
        cif.cmd_valid = 1'b0;
        repeat (3) @(negedge CLK);
        check("pre_rst_enable", Enable, 1);
        MR_n = 1'b0;
        #1;
        check("mid_rst_enable", Enable, 0);
        check("mid_rst_load", Load, 0);
        check("mid_rst_ready", cif.cmd_ready, 1);
        @(negedge CLK);
        MR_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge CLK);
            if (done || Enable || Load) begin
                seen++;
            end
        end
        check("no_done_after_rst", seen, 0);

        run(5, 4, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/decade_counter_ctrl.md
Name: decade_counter_ctrl

Overview:
- Synthesizable controller that drives the parallel-load/enable side of an external synchronous decade counter (P, Load, Enable) and reads its Q back.
- A command gives a preset value and a number of enabled count ticks. The block loads the preset, counts, checks every Q against an internal mod-10 model, then reports the result.
- It replaces hand-timed bench stimulus for counters in the communication/ports area. The ports on the counter side mirror the counter's own ports.

Parameters:
- CNT_W, 8, width of the tick-count field in a command.
- WRAP_W, 4, width of the saturating wrap counter (9->0 transitions).

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- MR_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  high only in IDLE.
- cmd_preset  input  4  value to load into the counter.
- cmd_count  input  CNT_W  number of Enable cycles after the load.
- abort  input  1  stops counting early; sampled in COUNT only.
- P  output  4  parallel data to the counter.
- Load  output  1  synchronous load strobe to the counter.
- Enable  output  1  count enable to the counter.
- Q  input  4  counter output.
- done  output  1  one-cycle pulse; the result fields below are valid while it is high.
- mismatch  output  1  at least one Q check failed in this operation.
- err_preset  output  1  cmd_preset > 9; the command was rejected.
- aborted  output  1  the operation ended because of abort.
- wraps  output  WRAP_W  count of 9->0 transitions, saturating at all-ones.
- final_q  output  4  Q sampled in FINAL.

Behaviour:
- Counter timing assumed by this block: the counter is synchronous; Load has priority over Enable; Q updates on the edge where Load or Enable is sampled high.
- Reset, asynchronous on MR_n low:
  - State goes to IDLE.
  - P=0, Load=0, Enable=0, done=0, mismatch=0, err_preset=0, aborted=0, wraps=0, final_q=0, cmd_ready=1.
  - Reset mid-operation abandons the operation; no done pulse is issued.
- States: IDLE, LOAD, COUNT, FINAL, DONE.
- IDLE:
  - Command accepted on an edge with cmd_valid & cmd_ready.
  - On accept, register preset and count, and clear mismatch, aborted and wraps.
  - If preset > 9: go to DONE with err_preset=1. No Load and no Enable are issued; final_q=0.
  - Otherwise go to LOAD.
- LOAD, 1 cycle:
  - Load=1 and P=preset; Enable=0.
  - Expected value exp := preset.
  - Next state is COUNT if count > 0, else FINAL.
- COUNT, count cycles:
  - Enable=1 and Load=0.
  - Each cycle: compare Q with exp and set mismatch (sticky) on inequality.
  - Then exp := (exp==9) ? 0 : exp+1. On 9->0, increment wraps, saturating.
  - abort high in a COUNT cycle: that cycle is the last counted cycle (its compare and increment still happen); set aborted; go to FINAL.
- FINAL, 1 cycle:
  - Enable=0 and Load=0.
  - Compare Q with exp and update mismatch.
  - final_q := Q.
- DONE, 1 cycle:
  - done=1; result fields hold their values until the next accept.
  - Next state is IDLE.
- Latency: accept edge to done high is count+3 cycles; with count=0 it is 3 cycles. A rejected preset gives done 1 cycle after accept.
- cmd_valid outside IDLE is ignored; no queueing.
- P holds preset from LOAD until the next accept.

Test Plan:
- Preset 7, count 5:
  - Load pulse exactly 1 cycle with P=7.
  - Enable high for exactly 5 cycles.
  - Q checked against 7,8,9,0,1,2.
  - done at accept+8; mismatch=0, wraps=1, final_q=2, aborted=0.
- Preset 3, count 0:
  - One Load pulse; Enable never asserted.
  - done at accept+3; final_q=3, wraps=0, mismatch=0.
- Preset 0, count 25:
  - done at accept+28; final_q=5, wraps=2, mismatch=0.
- Preset 12:
  - No Load or Enable pulse.
  - done at accept+1; err_preset=1.
  - cmd_ready back to 1 the next cycle.
- Faulty counter with Q stuck at 4, preset 4, count 3:
  - mismatch=1; final_q=4.
- Abort and reset:
  - Abort in the 2nd COUNT cycle of preset 8, count 10: Enable high for 2 cycles; final_q=0, wraps=1, aborted=1, mismatch=0.
  - Separate run: MR_n low mid-COUNT forces Enable=0 and Load=0 immediately, with no done pulse; the next command completes normally.
